// File: rtl/keccak_arb_pkg.sv
// Shared keccak definitions: data/length widths, mode codes and arbiter FSM states.
package keccak_arb_pkg;

    localparam int BW_DATA  = 64;
    localparam int BW_IBLEN = 11;
    localparam int BW_OBLEN = 10;

    // Keccak core operating modes as seen on the 2-bit mode field.
    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'd0,
        MODE_SHA3_512 = 2'd1,
        MODE_SHAKE128 = 2'd2,
        MODE_SHAKE256 = 2'd3
    } keccak_mode_t;

    // Arbiter FSM: IDLE arbitrates, RUN owns the core, GAP forces one idle cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Number of 64-bit output words needed to carry len output bytes.
    function automatic int unsigned obytes_words(input logic [BW_OBLEN-1:0] len);
        return (int'(len) + 7) / 8;
    endfunction

endpackage

// File: rtl/keccak_arb_rr_pick.sv
// Combinational round-robin picker: scans requests starting one past ptr.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int cand;

    // Walk the circular order ptr+1 .. ptr+NREQ and keep the first active request.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = IW'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keccak_arb.sv
// Round-robin arbiter sharing one keccak core between NREQ requesters,
// with a forced one-cycle gap between consecutive jobs.
module keccak_arb
    import keccak_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [NREQ-1:0]          i_req,
    input  logic [2*NREQ-1:0]        i_mode,
    input  logic [BW_DATA*NREQ-1:0]  i_ibytes,
    input  logic [BW_IBLEN*NREQ-1:0] i_ibytes_len,
    input  logic [BW_OBLEN*NREQ-1:0] i_obytes_len,
    output logic [NREQ-1:0]          o_gnt,
    output logic [NREQ-1:0]          o_ibytes_ready,
    output logic [BW_DATA-1:0]       o_obytes,
    output logic [NREQ-1:0]          o_obytes_valid,
    output logic [NREQ-1:0]          o_done,
    output logic                     o_busy,
    output logic [1:0]               k_mode,
    output logic [BW_DATA-1:0]       k_ibytes,
    output logic                     k_ibytes_valid,
    output logic [BW_IBLEN-1:0]      k_ibytes_len,
    output logic [BW_OBLEN-1:0]      k_obytes_len,
    input  logic [BW_DATA-1:0]       k_obytes,
    input  logic                     k_obytes_valid,
    input  logic                     k_obytes_done,
    input  logic                     k_ibytes_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [IW-1:0]        ptr;
    logic [NREQ-1:0]      pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [1:0]           mode_q;
    logic [BW_IBLEN-1:0]  ilen_q;
    logic [BW_OBLEN-1:0]  olen_q;
    logic                 run;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (i_req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign run    = (state == ST_RUN);
    assign o_busy = (state != ST_IDLE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant from IDLE, leave RUN on core done, GAP always lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_any) state_nxt = ST_RUN;
            ST_RUN:  if (k_obytes_done) state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant, owner pointer and job parameters are captured once per job and held until done.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_gnt  <= '0;
            ptr    <= IW'(NREQ - 1);
            mode_q <= '0;
            ilen_q <= '0;
            olen_q <= '0;
        end else if (state == ST_IDLE && pick_any) begin
            o_gnt  <= pick_onehot;
            ptr    <= pick_idx;
            mode_q <= i_mode[int'(pick_idx)*2 +: 2];
            ilen_q <= i_ibytes_len[int'(pick_idx)*BW_IBLEN +: BW_IBLEN];
            olen_q <= i_obytes_len[int'(pick_idx)*BW_OBLEN +: BW_OBLEN];
        end else if (run && k_obytes_done) begin
            o_gnt <= '0;
        end
    end

    // Core-side drive and per-requester routing exist only while a job owns the core.
    always_comb begin
        k_mode         = '0;
        k_ibytes       = '0;
        k_ibytes_valid = 1'b0;
        k_ibytes_len   = '0;
        k_obytes_len   = '0;
        o_ibytes_ready = '0;
        o_obytes_valid = '0;
        o_done         = '0;
        o_obytes       = '0;
        if (run) begin
            k_mode         = mode_q;
            k_ibytes       = i_ibytes[int'(ptr)*BW_DATA +: BW_DATA];
            k_ibytes_valid = 1'b1;
            k_ibytes_len   = ilen_q;
            k_obytes_len   = olen_q;
            o_ibytes_ready = o_gnt & {NREQ{k_ibytes_ready}};
            o_obytes_valid = o_gnt & {NREQ{k_obytes_valid}};
            o_done         = o_gnt & {NREQ{k_obytes_done}};
            o_obytes       = k_obytes;
        end
    end

endmodule
